// File: rtl/traffic_lights.sv
// traffic_lights - lamp sequencer for a single pedestrian/vehicle crossing.
//
// Clocked at 2 kHz, so one millisecond is two cycles. In NORMAL mode the
// lamps step through RED -> RED_YELLOW -> GREEN -> GREEN_BLINK -> YELLOW.
// OFF darkens every lamp. NOTRANSITION blinks yellow. The red, yellow and
// green durations can be reprogrammed from the command port, but only while
// in NOTRANSITION.
//
// Ports:
//   clk_0m002   in   2 kHz clock, rising edge
//   srst_i      in   asynchronous active-high reset
//   cmd_type_i  in   [2:0] command code, valid with cmd_val_i
//   cmd_val_i   in   command strobe
//   cmd_data_i  in   [15:0] duration in ms for codes 3/4/5
//   red_o       out  red lamp
//   yellow_o    out  yellow lamp
//   green_o     out  green lamp
//
// Build option: define TRAFFIC_LIGHTS_OFF_CMD_EN to implement command 1 (OFF).
// Without it, code 1 is ignored in the same way as codes 6 and 7.
//
// mode / phase    | meaning
// ----------------+----------------------------------------------
// NORMAL / RED    | red lamp on for red_ms
// NORMAL / RED_YEL| red+yellow lamps on for RED_YELLOW_MS
// NORMAL / GREEN  | green lamp on for green_ms
// NORMAL / G_BLINK| green blinks (off half first), BLINK_GREEN_TIME_TICK periods
// NORMAL / YELLOW | yellow lamp on for yellow_ms
// OFF             | all lamps dark
// NOTRANS         | yellow blinks (off half first), red/green dark

module traffic_lights #(
  parameter int unsigned BLINK_HALF_PERIOD_MS  = 10,
  parameter int unsigned BLINK_GREEN_TIME_TICK = 2,
  parameter int unsigned RED_YELLOW_MS         = 15,
  parameter int unsigned DEFAULT_RED_MS        = 1000,
  parameter int unsigned DEFAULT_YELLOW_MS     = 1000,
  parameter int unsigned DEFAULT_GREEN_MS      = 1000
) (
  input  logic        clk_0m002,
  input  logic        srst_i,
  input  logic [2:0]  cmd_type_i,
  input  logic        cmd_val_i,
  input  logic [15:0] cmd_data_i,
  output logic        red_o,
  output logic        yellow_o,
  output logic        green_o
);

  typedef enum logic [1:0] {
    MODE_NORMAL,
    MODE_OFF,
    MODE_NOTRANS
  } mode_t;

  typedef enum logic [2:0] {
    PH_RED,
    PH_RED_YELLOW,
    PH_GREEN,
    PH_GREEN_BLINK,
    PH_YELLOW
  } phase_t;

  // Terminal counts are the last cycle index of each phase (2*ms - 1).
  localparam logic [16:0] HALF_TC   = 17'(2 * BLINK_HALF_PERIOD_MS - 1);
  localparam logic [16:0] RY_TC     = 17'(2 * RED_YELLOW_MS - 1);
  localparam logic [7:0]  HALF_LAST = 8'(2 * BLINK_GREEN_TIME_TICK - 1);

  mode_t       mode;
  phase_t      phase;
  logic [16:0] cnt;
  logic [7:0]  half_cnt;
  logic        blink_on;
  logic [15:0] red_ms;
  logic [15:0] yellow_ms;
  logic [15:0] green_ms;

  function automatic logic [16:0] ms_tc(input logic [15:0] ms);
    return {ms, 1'b0} - 17'd1;
  endfunction

  always_ff @(posedge clk_0m002 or posedge srst_i) begin
    if (srst_i) begin
      mode      <= MODE_NORMAL;
      phase     <= PH_RED;
      cnt       <= '0;
      half_cnt  <= '0;
      blink_on  <= 1'b0;
      red_ms    <= 16'(DEFAULT_RED_MS);
      yellow_ms <= 16'(DEFAULT_YELLOW_MS);
      green_ms  <= 16'(DEFAULT_GREEN_MS);
      red_o     <= 1'b1;
      yellow_o  <= 1'b0;
      green_o   <= 1'b0;
    end else begin
      // Lamps are decoded from the pre-edge state, so a state change made on
      // one edge shows up on the lamps at the following edge.
      red_o    <= (mode == MODE_NORMAL) &&
                  (phase == PH_RED || phase == PH_RED_YELLOW);
      yellow_o <= ((mode == MODE_NORMAL) &&
                   (phase == PH_RED_YELLOW || phase == PH_YELLOW)) ||
                  ((mode == MODE_NOTRANS) && blink_on);
      green_o  <= (mode == MODE_NORMAL) &&
                  (phase == PH_GREEN || (phase == PH_GREEN_BLINK && blink_on));

      if (cmd_val_i && cmd_type_i == 3'd0 && mode != MODE_NORMAL) begin
        mode     <= MODE_NORMAL;
        phase    <= PH_RED;
        cnt      <= '0;
        half_cnt <= '0;
        blink_on <= 1'b0;
`ifdef TRAFFIC_LIGHTS_OFF_CMD_EN
      end else if (cmd_val_i && cmd_type_i == 3'd1) begin
        mode     <= MODE_OFF;
        cnt      <= '0;
        half_cnt <= '0;
        blink_on <= 1'b0;
`endif
      end else if (cmd_val_i && cmd_type_i == 3'd2) begin
        mode     <= MODE_NOTRANS;
        cnt      <= '0;
        half_cnt <= '0;
        blink_on <= 1'b0;
      end else begin
        // Duration loads; zero keeps the previous value.
        if (cmd_val_i && mode == MODE_NOTRANS && cmd_data_i != 16'd0) begin
          case (cmd_type_i)
            3'd3:    green_ms  <= cmd_data_i;
            3'd4:    red_ms    <= cmd_data_i;
            3'd5:    yellow_ms <= cmd_data_i;
            default: ;
          endcase
        end

        case (mode)
          MODE_NORMAL: begin
            case (phase)
              PH_RED: begin
                if (cnt == ms_tc(red_ms)) begin
                  phase <= PH_RED_YELLOW;
                  cnt   <= '0;
                end else begin
                  cnt <= cnt + 17'd1;
                end
              end
              PH_RED_YELLOW: begin
                if (cnt == RY_TC) begin
                  phase <= PH_GREEN;
                  cnt   <= '0;
                end else begin
                  cnt <= cnt + 17'd1;
                end
              end
              PH_GREEN: begin
                if (cnt == ms_tc(green_ms)) begin
                  phase    <= PH_GREEN_BLINK;
                  cnt      <= '0;
                  half_cnt <= '0;
                  blink_on <= 1'b0;
                end else begin
                  cnt <= cnt + 17'd1;
                end
              end
              PH_GREEN_BLINK: begin
                if (cnt == HALF_TC) begin
                  cnt <= '0;
                  if (half_cnt == HALF_LAST) begin
                    phase    <= PH_YELLOW;
                    half_cnt <= '0;
                    blink_on <= 1'b0;
                  end else begin
                    half_cnt <= half_cnt + 8'd1;
                    blink_on <= ~blink_on;
                  end
                end else begin
                  cnt <= cnt + 17'd1;
                end
              end
              PH_YELLOW: begin
                if (cnt == ms_tc(yellow_ms)) begin
                  phase <= PH_RED;
                  cnt   <= '0;
                end else begin
                  cnt <= cnt + 17'd1;
                end
              end
              default: begin
                phase <= PH_RED;
                cnt   <= '0;
              end
            endcase
          end
          MODE_NOTRANS: begin
            if (cnt == HALF_TC) begin
              cnt      <= '0;
              blink_on <= ~blink_on;
            end else begin
              cnt <= cnt + 17'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_traffic_lights.sv
`timescale 1us/1ns

module tb_traffic_lights;

  logic        clk_0m002 = 1'b0;
  logic        srst_i    = 1'b0;
  logic [2:0]  cmd_type_i = 3'd0;
  logic        cmd_val_i  = 1'b0;
  logic [15:0] cmd_data_i = 16'd0;
  logic        red_o, yellow_o, green_o;
  logic [2:0]  lamps;

  int n_cmp = 0;
  int n_err = 0;

  assign lamps = {red_o, yellow_o, green_o};

  traffic_lights dut (
    .clk_0m002  (clk_0m002),
    .srst_i     (srst_i),
    .cmd_type_i (cmd_type_i),
    .cmd_val_i  (cmd_val_i),
    .cmd_data_i (cmd_data_i),
    .red_o      (red_o),
    .yellow_o   (yellow_o),
    .green_o    (green_o)
  );

  always #250 clk_0m002 = ~clk_0m002;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk_0m002);
    #1;
  endtask

  // Reset held across one rising edge, released just after it.
  task automatic do_reset();
    srst_i = 1'b1;
    step();
    srst_i = 1'b0;
  endtask

  // One-cycle command strobe; returns positioned just after the sampling edge.
  task automatic send_cmd(input logic [2:0] t, input logic [15:0] d);
    cmd_type_i = t;
    cmd_data_i = d;
    cmd_val_i  = 1'b1;
    step();
    cmd_val_i  = 1'b0;
    cmd_data_i = 16'd0;
  endtask

  // Counts consecutive samples showing pattern pat, bounded by limit.
  task automatic run_len(input logic [2:0] pat, input int limit, output int n);
    n = 0;
    while (lamps === pat && n < limit) begin
      n++;
      step();
    end
  endtask

  task automatic test_reset();
    srst_i = 1'b1;
    #10;
    n_cmp++;
    if (lamps !== 3'b100) begin
      n_err++;
      $display("FAIL reset_hold: lamps=%b expected=100", lamps);
    end
    step();
    srst_i = 1'b0;
    step();
    n_cmp++;
    if (lamps !== 3'b100) begin
      n_err++;
      $display("FAIL reset_release: lamps=%b expected=100", lamps);
    end
  endtask

  task automatic test_normal_cycle();
    logic [2:0] pats [9];
    int         lens [9];
    int         n;
    pats = '{3'b100, 3'b110, 3'b001, 3'b000, 3'b001, 3'b000, 3'b001, 3'b010, 3'b100};
    lens = '{20, 30, 20, 20, 20, 20, 20, 20, 20};
    do_reset();
    send_cmd(3'd2, 16'd0);
    step();
    send_cmd(3'd3, 16'd10);
    step();
    send_cmd(3'd4, 16'd10);
    step();
    send_cmd(3'd5, 16'd10);
    step();
    send_cmd(3'd0, 16'd0);
    step();
    for (int i = 0; i < 9; i++) begin
      run_len(pats[i], lens[i] + 10, n);
      n_cmp++;
      if (n !== lens[i]) begin
        n_err++;
        $display("FAIL normal_phase%0d(%b): cycles=%0d expected=%0d", i, pats[i], n, lens[i]);
      end
    end
    n_cmp++;
    if (lamps !== 3'b110) begin
      n_err++;
      $display("FAIL normal_wrap: lamps=%b expected=110", lamps);
    end
  endtask

  task automatic test_notransition();
    int n;
    do_reset();
    send_cmd(3'd2, 16'd0);
    step();
    for (int i = 0; i < 4; i++) begin
      run_len((i % 2 == 0) ? 3'b000 : 3'b010, 40, n);
      n_cmp++;
      if (n !== 20) begin
        n_err++;
        $display("FAIL notrans_half%0d: cycles=%0d expected=20", i, n);
      end
    end
  endtask

  task automatic test_load_ignored_in_normal();
    int n;
    do_reset();
    send_cmd(3'd4, 16'd50);
    run_len(3'b100, 2100, n);
    n_cmp++;
    if (n !== 2000) begin
      n_err++;
      $display("FAIL load_in_normal_red: cycles=%0d expected=2000", n);
    end
    n_cmp++;
    if (lamps !== 3'b110) begin
      n_err++;
      $display("FAIL load_in_normal_next: lamps=%b expected=110", lamps);
    end
  endtask

  task automatic test_zero_data();
    int n;
    do_reset();
    send_cmd(3'd2, 16'd0);
    step();
    send_cmd(3'd3, 16'd0);
    step();
    send_cmd(3'd0, 16'd0);
    step();
    run_len(3'b100, 2100, n);
    n_cmp++;
    if (n !== 2000) begin
      n_err++;
      $display("FAIL zero_data_red: cycles=%0d expected=2000", n);
    end
    run_len(3'b110, 40, n);
    n_cmp++;
    if (n !== 30) begin
      n_err++;
      $display("FAIL zero_data_red_yellow: cycles=%0d expected=30", n);
    end
    run_len(3'b001, 2100, n);
    n_cmp++;
    if (n !== 2000) begin
      n_err++;
      $display("FAIL zero_data_green: cycles=%0d expected=2000", n);
    end
  endtask

  // Continues from test_zero_data, which leaves the design in GREEN_BLINK.
  task automatic test_async_reset();
    int n;
    repeat (5) step();
    n_cmp++;
    if (lamps !== 3'b000) begin
      n_err++;
      $display("FAIL blink_before_reset: lamps=%b expected=000", lamps);
    end
    srst_i = 1'b1;
    #1;
    n_cmp++;
    if (lamps !== 3'b100) begin
      n_err++;
      $display("FAIL async_reset: lamps=%b expected=100", lamps);
    end
    step();
    srst_i = 1'b0;
    step();
    run_len(3'b100, 2100, n);
    n_cmp++;
    if (n !== 2000) begin
      n_err++;
      $display("FAIL red_after_reset: cycles=%0d expected=2000", n);
    end
  endtask

  task automatic test_off_cmd();
    int n;
    logic [2:0] exp_off;
    logic [2:0] exp_back;
`ifdef TRAFFIC_LIGHTS_OFF_CMD_EN
    exp_off  = 3'b000;
    exp_back = 3'b100;
`else
    exp_off  = 3'b001;
    exp_back = 3'b001;
`endif
    do_reset();
    send_cmd(3'd2, 16'd0);
    step();
    send_cmd(3'd3, 16'd20);
    step();
    send_cmd(3'd4, 16'd5);
    step();
    send_cmd(3'd0, 16'd0);
    step();
    run_len(3'b100, 30, n);
    n_cmp++;
    if (n !== 10) begin
      n_err++;
      $display("FAIL off_test_red: cycles=%0d expected=10", n);
    end
    run_len(3'b110, 40, n);
    repeat (3) step();
    send_cmd(3'd1, 16'd0);
    n_cmp++;
    if (lamps !== 3'b001) begin
      n_err++;
      $display("FAIL off_latency: lamps=%b expected=001", lamps);
    end
    step();
    n_cmp++;
    if (lamps !== exp_off) begin
      n_err++;
      $display("FAIL off_applied: lamps=%b expected=%b", lamps, exp_off);
    end
    step();
    send_cmd(3'd6, 16'd7);
    step();
    n_cmp++;
    if (lamps !== exp_off) begin
      n_err++;
      $display("FAIL cmd6_ignored: lamps=%b expected=%b", lamps, exp_off);
    end
    send_cmd(3'd0, 16'd0);
    step();
    n_cmp++;
    if (lamps !== exp_back) begin
      n_err++;
      $display("FAIL back_to_normal: lamps=%b expected=%b", lamps, exp_back);
    end
`ifdef TRAFFIC_LIGHTS_OFF_CMD_EN
    run_len(3'b100, 30, n);
    n_cmp++;
    if (n !== 10) begin
      n_err++;
      $display("FAIL red_after_off: cycles=%0d expected=10", n);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_normal_cycle();
    test_notransition();
    test_load_ignored_in_normal();
    test_zero_data();
    test_async_reset();
    test_off_cmd();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/traffic_lights.md
# traffic_lights

Traffic-light controller for a single pedestrian/vehicle crossing, clocked at 2 kHz (0.5 ms period, so 1 ms = 2 cycles). It drives the red, yellow and green lamps through the standard cycle red → red+yellow → green → blinking green → yellow. A simple valid-qualified command port lets a host switch modes and program the red, yellow and green phase durations in milliseconds. It sits between the host command bus and the lamp drivers.

## Interface
- BLINK_HALF_PERIOD_MS, 10: duration of each on or off half of a blink, in ms.
- BLINK_GREEN_TIME_TICK, 2: number of full off+on blink periods in the blinking-green phase.
- RED_YELLOW_MS, 15: red+yellow phase duration, in ms.
- DEFAULT_RED_MS, 1000: red duration loaded at reset.
- DEFAULT_YELLOW_MS, 1000: yellow duration loaded at reset.
- DEFAULT_GREEN_MS, 1000: green duration loaded at reset.

Ports:
- clk_0m002  in  1  2 kHz clock; all logic on its rising edge.
- srst_i  in  1  reset; asynchronous, active-high.
- cmd_type_i  in  3  command code; sampled when cmd_val_i=1.
- cmd_val_i  in  1  command strobe; one command per cycle it is high.
- cmd_data_i  in  16  duration in ms, used by codes 3/4/5.
- red_o  out  1  red lamp.
- yellow_o  out  1  yellow lamp.
- green_o  out  1  green lamp.

## Operation
Modes:
- NORMAL: cycles through the lamp phases.
- OFF: all lamps dark.
- NOTRANSITION: yellow blinks (off/on, BLINK_HALF_PERIOD_MS each); red and green dark.

NORMAL phases (lamps shown as red, yellow, green):
- RED: 1,0,0 for red_ms.
- RED_YELLOW: 1,1,0 for RED_YELLOW_MS.
- GREEN: 0,0,1 for green_ms.
- GREEN_BLINK: BLINK_GREEN_TIME_TICK periods, each an off half (0,0,0) then an on half (0,0,1) of BLINK_HALF_PERIOD_MS.
- YELLOW: 0,1,0 for yellow_ms.
- Then back to RED.

Commands (cmd_type_i):
- 0: enter NORMAL at RED with the phase counter cleared. Ignored if already in NORMAL.
- 1: enter OFF.
- 2: enter NOTRANSITION; the blink starts with the off half.
- 3 / 4 / 5: load green_ms / red_ms / yellow_ms from cmd_data_i. Accepted only in NOTRANSITION; ignored in other modes.
- Loaded values take effect the next time that phase is entered.
- cmd_data_i=0 is ignored; the previous value is kept.
- Codes 6 and 7 are ignored.

Reset:
- Mode NORMAL, phase RED, counters cleared.
- red_ms, yellow_ms and green_ms take their DEFAULT_* values.
- Outputs on reset: red_o=1, yellow_o=0, green_o=0.
- Reset asserted mid-operation aborts the current phase immediately and returns to this state.

## Timing
- Phase length in cycles is 2×ms.
- Phase counter is 17 bits, so a 16-bit ms value times 2 never overflows.
- A phase of N ms holds its lamp pattern for exactly 2N consecutive cycles.
- The next phase's pattern appears on the following cycle.
- Outputs are registered.
- A command sampled on edge k changes the outputs from edge k+1 (one-cycle latency).
- Durations are applied with no off-by-one error.

## Configuration
- Macro: TRAFFIC_LIGHTS_OFF_CMD_EN.
- Defined: command 1 (OFF) is implemented as described.
- Undefined: OFF mode logic is not compiled and code 1 is ignored like codes 6 and 7.

## Test plan
- Default parameters; reset, then cmd 2, cmd 3 (data 10), cmd 4 (data 10), cmd 5 (data 10), then cmd 0, sending one command every other cycle. Required response:
  - red for 20 cycles;
  - red+yellow for 30 cycles;
  - green for 20 cycles;
  - 2× (20 cycles dark, 20 cycles green);
  - yellow for 20 cycles;
  - then red again.
- Reset, then cmd 2 → lamps 0,0,0 for 20 cycles, then yellow for 20 cycles, repeating. red_o and green_o stay 0.
- In NORMAL, send cmd 4 with data 50 → ignored; the red phase stays at the DEFAULT_RED_MS value (2000 cycles).
- In NOTRANSITION, send cmd 3 with data 0, then cmd 0 → green lasts 2000 cycles (the default is kept).
- Assert srst_i during GREEN_BLINK → outputs become 1,0,0 asynchronously. After release, red lasts 2000 cycles.
- Send cmd 1 during GREEN → all outputs 0 from the next cycle. Then cmd 0 → red from the next cycle. cmd 6 has no effect.
